nios2_system_spi_slave: RTL and testbench

SPI slave (peripheral-side) endpoint for the Nios II system: the receiving end of the SPI master port, for use where an external SPI master drives SCLK/SS_n. Fixed mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. SPI pins are oversampled in the single `clk` domain. The block exposes the same two-cycle CPU register-port style as the master, with holding registers, status flags and a registered IRQ.

---
 rtl/nios2_system_spi_slave.sv | 171 +++++++++++++++++
 tb/tb_nios2_system_spi_slave.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_system_spi_slave.sv
// nios2_system_spi_slave: mode-0, MSB-first SPI slave with pins oversampled
// in the clk domain, a two-cycle CPU register port, status flags and IRQ.
module nios2_system_spi_slave #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
);
  localparam int CW = $clog2(DATABITS);
  localparam logic [CW-1:0] LAST = CW'(DATABITS - 1);

  logic [SYNC_STAGES-1:0] sclk_sq, ss_sq, mosi_sq, rdy_sq;
  logic sclk_pq, ss_pq, mosi_pq, armed_q;
  logic rise_q, fall_q, ssf_q, ssr_q;
  logic sclk_s, ss_s;
  logic ph_q;

  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [DATABITS-1:0] rx_sh_q, rx_sh_d, rx_hold_q, rx_hold_d;
  logic [DATABITS-1:0] tx_sh_q, tx_sh_d, tx_hold_q, tx_hold_d;
  logic [DATABITS-1:0] rx_next;
  logic rrdy_q, rrdy_d, trdy_q, trdy_d, tur_q, tur_d;
  logic toe_q, toe_d, roe_q, roe_d;
  logic [5:0] ctrl_q, ctrl_d;
  logic [15:0] dout_q, dout_d, stat;
  logic irq_q, irq_d;

  logic rd2, wr2, rd_rx, wr_tx, wr_st, wr_ct;
  logic sel, load, shift, take, done;
  logic unused_ok;

  assign sclk_s = sclk_sq[SYNC_STAGES-1];
  assign ss_s   = ss_sq[SYNC_STAGES-1];

  // armed_q blocks frames until SS_n is seen high after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sq <= '0;
      ss_sq   <= '1;
      mosi_sq <= '0;
      rdy_sq  <= '0;
      sclk_pq <= 1'b0;
      ss_pq   <= 1'b1;
      mosi_pq <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      ssf_q   <= 1'b0;
      ssr_q   <= 1'b0;
    end else begin
      sclk_sq <= {sclk_sq[SYNC_STAGES-2:0], SCLK};
      ss_sq   <= {ss_sq[SYNC_STAGES-2:0], SS_n};
      mosi_sq <= {mosi_sq[SYNC_STAGES-2:0], MOSI};
      rdy_sq  <= {rdy_sq[SYNC_STAGES-2:0], 1'b1};
      sclk_pq <= sclk_s;
      ss_pq   <= ss_s;
      mosi_pq <= mosi_sq[SYNC_STAGES-1];
      armed_q <= armed_q | (rdy_sq[SYNC_STAGES-1] & ss_s);
      rise_q  <= sclk_s & ~sclk_pq;
      fall_q  <= ~sclk_s & sclk_pq;
      ssf_q   <= armed_q & ss_pq & ~ss_s;
      ssr_q   <= ss_s & ~ss_pq;
    end
  end

  assign rd2   = spi_select & ~read_n & ph_q;
  assign wr2   = spi_select & ~write_n & ph_q;
  assign rd_rx = rd2 & (mem_addr == 3'd0);
  assign wr_tx = wr2 & (mem_addr == 3'd1);
  assign wr_st = wr2 & (mem_addr == 3'd2);
  assign wr_ct = wr2 & (mem_addr == 3'd3);

  assign sel   = armed_q & ~ss_pq;
  assign load  = sel & (ssf_q | (fall_q & (bitcnt_q == '0)));
  assign shift = sel & fall_q & (bitcnt_q != '0);
  assign take  = sel & rise_q;
  assign done  = take & (bitcnt_q == LAST);
  assign rx_next = {rx_sh_q[DATABITS-2:0], mosi_pq};

  assign stat = {6'b0, sel, roe_q | toe_q | tur_q, rrdy_q, trdy_q,
                 tur_q, toe_q, roe_q, 3'b0};

  always_comb begin
    bitcnt_d  = bitcnt_q;
    rx_sh_d   = rx_sh_q;
    rx_hold_d = rx_hold_q;
    tx_sh_d   = tx_sh_q;
    tx_hold_d = tx_hold_q;
    ctrl_d    = ctrl_q;
    if (ssf_q | ssr_q) begin
      bitcnt_d = '0;
    end else if (take) begin
      rx_sh_d  = rx_next;
      bitcnt_d = bitcnt_q + 1'b1;
    end
    if (done) rx_hold_d = rx_next;
    unique case (1'b1)
      load:    tx_sh_d = trdy_q ? '0 : tx_hold_q;
      shift:   tx_sh_d = tx_sh_q << 1;
      default: tx_sh_d = tx_sh_q;
    endcase
    if (wr_tx & trdy_q) tx_hold_d = data_from_cpu[DATABITS-1:0];
    if (wr_ct) ctrl_d = data_from_cpu[8:3];
    // flag sets take priority over clears in the same cycle
    rrdy_d = done | (rrdy_q & ~(rd_rx | wr_st));
    roe_d  = (done & rrdy_q & ~rd_rx) | (roe_q & ~wr_st);
    tur_d  = (load & trdy_q) | (tur_q & ~wr_st);
    toe_d  = (wr_tx & ~trdy_q) | (toe_q & ~wr_st);
    trdy_d = (load & ~trdy_q) | (trdy_q & ~wr_tx);
    irq_d  = |(stat[8:3] & ctrl_q);
    case (mem_addr)
      3'd0:    dout_d = {{(16-DATABITS){1'b0}}, rx_hold_q};
      3'd2:    dout_d = stat;
      3'd3:    dout_d = {7'b0, ctrl_q, 3'b0};
      default: dout_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q      <= 1'b0;
      bitcnt_q  <= '0;
      rx_sh_q   <= '0;
      rx_hold_q <= '0;
      tx_sh_q   <= '0;
      tx_hold_q <= '0;
      rrdy_q    <= 1'b0;
      trdy_q    <= 1'b1;
      tur_q     <= 1'b0;
      toe_q     <= 1'b0;
      roe_q     <= 1'b0;
      ctrl_q    <= '0;
      dout_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      ph_q      <= spi_select & ~(read_n & write_n) & ~ph_q;
      bitcnt_q  <= bitcnt_d;
      rx_sh_q   <= rx_sh_d;
      rx_hold_q <= rx_hold_d;
      tx_sh_q   <= tx_sh_d;
      tx_hold_q <= tx_hold_d;
      rrdy_q    <= rrdy_d;
      trdy_q    <= trdy_d;
      tur_q     <= tur_d;
      toe_q     <= toe_d;
      roe_q     <= roe_d;
      ctrl_q    <= ctrl_d;
      dout_q    <= dout_d;
      irq_q     <= irq_d;
    end
  end

  assign data_to_cpu = dout_q;
  assign irq         = irq_q;
  assign MISO        = sel & tx_sh_q[DATABITS-1];
  assign MISO_oe     = sel;
  assign unused_ok   = ^{data_from_cpu[15:9], rx_sh_q[DATABITS-1]};
endmodule

// File: tb/tb_nios2_system_spi_slave.sv
// tb_nios2_system_spi_slave: directed plus randomized frames checked
// against an event-level model of the slave's flags and data path.
module tb_nios2_system_spi_slave;
  localparam int H = 25;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu;
  logic        read_n, write_n, spi_select;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        SCLK, SS_n, MOSI;
  logic        MISO, MISO_oe;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_hold, m_sh, m_rx;
  bit m_trdy, m_rrdy, m_tur, m_toe, m_roe;
  logic [5:0] m_ctrl;

  nios2_system_spi_slave dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr),
    .data_from_cpu(data_from_cpu), .read_n(read_n),
    .write_n(write_n), .spi_select(spi_select),
    .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] ex);
    n_tests++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, ex);
    end
  endtask

  task automatic m_reset();
    m_hold = 0; m_sh = 0; m_rx = 0; m_ctrl = 0;
    m_trdy = 1; m_rrdy = 0; m_tur = 0; m_toe = 0; m_roe = 0;
  endtask

  task automatic m_txwr(input logic [7:0] b);
    if (m_trdy) begin m_hold = b; m_trdy = 0; end
    else m_toe = 1;
  endtask

  task automatic m_load();
    if (!m_trdy) begin m_sh = m_hold; m_trdy = 1; end
    else begin m_sh = 8'h00; m_tur = 1; end
  endtask

  task automatic m_recv(input logic [7:0] b);
    if (m_rrdy) m_roe = 1;
    m_rrdy = 1;
    m_rx = b;
  endtask

  task automatic m_stclr();
    m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0;
  endtask

  function automatic logic [15:0] m_status(input bit busy);
    return {6'b0, busy, m_roe | m_toe | m_tur, m_rrdy, m_trdy,
            m_tur, m_toe, m_roe, 3'b0};
  endfunction

  function automatic logic [15:0] m_irq();
    logic [15:0] s;
    s = m_status(1'b0);
    return {15'b0, |(s[8:3] & m_ctrl)};
  endfunction

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
    repeat (2) @(posedge clk);
    #1;
    spi_select = 0; write_n = 1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    spi_select = 1; read_n = 0; mem_addr = a;
    @(posedge clk); #1;
    d = data_to_cpu;
    @(posedge clk); #1;
    spi_select = 0; read_n = 1;
  endtask

  task automatic w_tx(input logic [7:0] b);
    cpu_write(3'd1, {8'h00, b});
    m_txwr(b);
  endtask

  task automatic w_ctrl(input logic [5:0] c);
    cpu_write(3'd3, {7'b0, c, 3'b0});
    m_ctrl = c;
  endtask

  task automatic st_clr();
    cpu_write(3'd2, 16'($urandom));
    m_stclr();
  endtask

  task automatic rd_st(input string tag, input bit busy);
    logic [15:0] d;
    cpu_read(3'd2, d);
    chk(tag, d, m_status(busy));
  endtask

  task automatic rd_rx(input string tag);
    logic [15:0] d;
    cpu_read(3'd0, d);
    chk(tag, d, {8'h00, m_rx});
    m_rrdy = 0;
  endtask

  task automatic sbits(input int n, input logic [7:0] mo,
                       output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = mo[i];
      repeat (H) @(posedge clk);
      #1;
      mi[i] = MISO;
      SCLK = 1;
      repeat (H) @(posedge clk);
      #1;
      SCLK = 0;
    end
  endtask

  task automatic f_start();
    SS_n = 0;
    repeat (10) @(posedge clk);
    #1;
    m_load();
  endtask

  task automatic f_byte(input string tag, input logic [7:0] mo);
    logic [7:0] mi, ex;
    ex = m_sh;
    sbits(8, mo, mi);
    chk(tag, {8'h00, mi}, {8'h00, ex});
    m_recv(mo);
    m_load();
  endtask

  task automatic f_end();
    repeat (H) @(posedge clk);
    #1;
    SS_n = 1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] mi;
    int nb;
    reset = 1; SS_n = 1; SCLK = 0; MOSI = 0;
    read_n = 1; write_n = 1; spi_select = 0;
    mem_addr = 0; data_from_cpu = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", data_to_cpu, 16'h0000);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    chk("rst_miso", {14'b0, MISO_oe, MISO}, 16'h0000);
    reset = 0;
    repeat (5) @(posedge clk);
    #1;
    rd_st("rst_status", 0);

    w_tx(8'h3C);
    f_start();
    rd_st("t1_busy", 1);
    f_byte("t1_miso", 8'hA5);
    f_end();
    rd_st("t1_status", 0);
    rd_rx("t1_rx");

    st_clr();
    w_tx(8'h9A);
    f_start();
    w_tx(8'h56);
    f_byte("t2_miso1", 8'h12);
    f_byte("t2_miso2", 8'h34);
    f_end();
    rd_st("t2_status", 0);
    rd_rx("t2_rx");

    st_clr();
    w_ctrl(6'b000100);
    f_start();
    f_byte("t3_miso", 8'hC3);
    f_end();
    chk("t3_irq", {15'b0, irq}, m_irq());
    rd_st("t3_status", 0);
    cpu_write(3'd2, 16'h0000);
    m_stclr();
    chk("t3_irq_hold", {15'b0, irq}, 16'h0001);
    @(posedge clk); #1;
    chk("t3_irq_drop", {15'b0, irq}, m_irq());

    w_tx(8'h11);
    w_tx(8'h22);
    rd_st("t4_status", 0);
    f_start();
    f_byte("t4_miso", 8'h5A);
    f_end();
    st_clr();

    w_tx(8'h77);
    f_start();
    sbits(4, 8'hF0, mi);
    chk("t5_part_miso", {12'h000, mi[7:4]}, {12'h000, m_sh[7:4]});
    f_end();
    rd_st("t5_status", 0);
    f_start();
    f_byte("t5_miso", 8'hFF);
    f_end();
    rd_rx("t5_rx");

    st_clr();
    w_tx(8'h44);
    f_start();
    sbits(3, 8'h81, mi);
    chk("t6_part_miso", {13'h0, mi[7:5]}, {13'h0, m_sh[7:5]});
    reset = 1;
    #1;
    chk("t6_rst_dout", data_to_cpu, 16'h0000);
    chk("t6_rst_out", {13'b0, irq, MISO_oe, MISO}, 16'h0000);
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_oe_unarmed", {15'b0, MISO_oe}, 16'h0000);
    SS_n = 1;
    repeat (10) @(posedge clk);
    #1;
    rd_st("t6_status", 0);
    f_start();
    f_byte("t6_miso", 8'h81);
    f_end();
    rd_rx("t6_rx");

    for (int it = 0; it < 8; it++) begin
      w_ctrl(6'($urandom_range(0, 63)));
      if ($urandom_range(0, 1) == 1) w_tx(8'($urandom));
      nb = $urandom_range(1, 2);
      f_start();
      if (nb == 2 && $urandom_range(0, 1) == 1) w_tx(8'($urandom));
      f_byte("rnd_miso0", 8'($urandom));
      if (nb == 2) f_byte("rnd_miso1", 8'($urandom));
      f_end();
      chk("rnd_irq", {15'b0, irq}, m_irq());
      rd_st("rnd_status", 0);
      if ($urandom_range(0, 1) == 1) rd_rx("rnd_rx");
      if ($urandom_range(0, 2) == 0) st_clr();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
